// File: rtl/mem_pkg.sv
// Shared types and helpers for the MEM-stage data memory unit: size codes,
// store-buffer entry layout, byte-enable generation and load extension.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_B  = 2'b00,
        SZ_H  = 2'b01,
        SZ_W  = 2'b10,
        SZ_WX = 2'b11
    } mem_size_e;

    localparam int WADDR_W = 30;

    typedef struct packed {
        logic [WADDR_W-1:0] waddr;
        logic [3:0]         be;
        logic [31:0]        data;
    } wbuf_entry_t;

    function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] be;
        case (size)
            SZ_B:    be = 4'b0001 << a;
            SZ_H:    be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] d;
        case (size)
            SZ_B:    d = {4{wdata[7:0]}};
            SZ_H:    d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] a, input logic sext);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            default: b = word[31:24];
        endcase
        h = a[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_B:    r = {{24{sext & b[7]}}, b};
            SZ_H:    r = {{16{sext & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        logic m;
        case (size)
            SZ_B:    m = 1'b0;
            SZ_H:    m = a[0];
            default: m = (a != 2'b00);
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_wbuf.sv
// Store buffer FIFO: circular storage with per-entry valid bits, registered
// full/empty flags and a parallel word-address hit compare for load hazards.
module mem_wbuf
    import mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  wbuf_entry_t        push_entry,
    input  logic               pop,
    input  logic [WADDR_W-1:0] hit_waddr,
    output wbuf_entry_t        head_entry,
    output logic               full,
    output logic               empty,
    output logic               hit
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [DEPTH-1:0] SLOT0    = DEPTH'(1);

    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [PTR_W:0]   count_r;
    logic [PTR_W:0]   count_nxt_s;
    logic [DEPTH-1:0] valid_r;
    logic [DEPTH-1:0] valid_nxt_s;
    logic             full_r;
    logic             empty_r;
    logic             hit_s;
    wbuf_entry_t      entry_r [DEPTH];

    // Occupancy update; push and pop together leave the count unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({push, pop})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Valid bits: clear the drained head slot, set the freshly written tail slot.
    always_comb begin
        valid_nxt_s = (valid_r & ~(pop ? (SLOT0 << head_r) : '0))
                    | (push ? (SLOT0 << tail_r) : '0);
    end

    // Pointer, count and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            valid_r <= '0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            if (push) tail_r <= tail_r + PTR_ONE;
            if (pop)  head_r <= head_r + PTR_ONE;
            count_r <= count_nxt_s;
            valid_r <= valid_nxt_s;
            full_r  <= (count_nxt_s == CNT_FULL);
            empty_r <= (count_nxt_s == '0);
        end
    end

    // Entry payload storage; contents are meaningless unless the slot is valid.
    always_ff @(posedge clk) begin
        if (push) entry_r[tail_r] <= push_entry;
    end

    // A load conflicts with any live entry targeting the same word.
    always_comb begin
        hit_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_s = hit_s | (valid_r[i] && (entry_r[i].waddr == hit_waddr));
        end
    end

    assign head_entry = entry_r[head_r];
    assign full       = full_r;
    assign empty      = empty_r;
    assign hit        = hit_s;

endmodule

// File: rtl/mem_stage_wbuf.sv
// MEM-stage data memory: single-port word RAM fronted by a store buffer that
// drains in load-free cycles. Optional MEM_ALIGN_CHECK_EN adds align_err.
module mem_stage_wbuf
    import mem_pkg::*;
#(
    parameter int ADDR_W     = 11,
    parameter int WBUF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m_valid,
    output logic        m_ready,
    input  logic        m_we,
    input  logic [1:0]  m_size,
    input  logic        m_sext,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        wbuf_empty
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic        align_err
`endif
);

    logic [ADDR_W-1:0]  idx_s;
    logic [WADDR_W-1:0] req_waddr_s;
    logic               mis_s;
    logic               full_s;
    logic               empty_s;
    logic               hit_s;
    logic               ready_s;
    logic               accept_s;
    logic               rd_en_s;
    logic               push_s;
    logic               pop_s;
    wbuf_entry_t        push_entry_s;
    wbuf_entry_t        head_s;
    logic               rd_valid_r;
    logic [31:0]        rd_data_r;
    logic [31:0]        ram_r [2**ADDR_W];
    logic               unused_addr_s;

    assign idx_s       = m_addr[ADDR_W+1:2];
    assign req_waddr_s = WADDR_W'(idx_s);

`ifdef MEM_ALIGN_CHECK_EN
    assign mis_s = is_misaligned(m_size, m_addr[1:0]);
`else
    assign mis_s = 1'b0;
`endif

    // Stores only wait for space; loads wait out any pending store to the same word.
    assign ready_s  = m_we ? !full_s : !hit_s;
    assign accept_s = m_valid && ready_s;
    assign rd_en_s  = accept_s && !m_we && !mis_s;
    assign push_s   = accept_s && m_we && !mis_s;
    assign pop_s    = !rd_en_s && !empty_s;

    assign push_entry_s = '{waddr: req_waddr_s,
                            be:    be_gen(m_size, m_addr[1:0]),
                            data:  store_lanes(m_size, m_wdata)};

    mem_wbuf #(
        .DEPTH(WBUF_DEPTH)
    ) u_wbuf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .hit_waddr  (req_waddr_s),
        .head_entry (head_s),
        .full       (full_s),
        .empty      (empty_s),
        .hit        (hit_s)
    );

    // Drain port: byte-masked write of the buffer head.
    always_ff @(posedge clk) begin
        if (pop_s) begin
            for (int b = 0; b < 4; b++) begin
                if (head_s.be[b]) ram_r[head_s.waddr[ADDR_W-1:0]][8*b +: 8] <= head_s.data[8*b +: 8];
            end
        end
    end

    // Load result register; rd_data holds its value between loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_r <= 1'b0;
            rd_data_r  <= 32'h0000_0000;
        end else begin
            rd_valid_r <= rd_en_s;
            if (rd_en_s) rd_data_r <= load_extend(ram_r[idx_s], m_size, m_addr[1:0], m_sext);
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic align_err_r;

    // One-cycle flag for an accepted but dropped misaligned request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            align_err_r <= 1'b0;
        end else begin
            align_err_r <= accept_s && mis_s;
        end
    end

    assign align_err = align_err_r;
`endif

    // Address bits above the RAM index alias onto the same word.
    assign unused_addr_s = ^{m_addr[31:ADDR_W+2], head_s.waddr[WADDR_W-1:ADDR_W]};

    assign m_ready    = ready_s;
    assign rd_valid   = rd_valid_r;
    assign rd_data    = rd_data_r;
    assign wbuf_empty = empty_s;

endmodule

// File: tb/tb_mem_stage_wbuf.sv
// Self-checking bench for mem_stage_wbuf: directed table, corner sequences and
// random traffic against a byte-level memory model with a pending-store queue.
module tb_mem_stage_wbuf;

    localparam int AW  = 11;
    localparam int DEP = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m_valid;
    logic        m_ready;
    logic        m_we;
    logic [1:0]  m_size;
    logic        m_sext;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        wbuf_empty;
`ifdef MEM_ALIGN_CHECK_EN
    logic        align_err;
`endif

    mem_stage_wbuf #(.ADDR_W(AW), .WBUF_DEPTH(DEP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_we       (m_we),
        .m_size     (m_size),
        .m_sext     (m_sext),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .wbuf_empty (wbuf_empty)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .align_err  (align_err)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] a;
        logic [1:0]  sz;
        logic [31:0] d;
    } st_t;

    bit [7:0]    ref_bytes [0:(4<<AW)-1];
    st_t         q[$];
    bit          exp_rdv = 1'b0;
    logic [31:0] exp_rd  = 32'h0;
    bit          exp_al  = 1'b0;
    bit          last_ready;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, got, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) & ((32'd1 << AW) - 32'd1));
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
    endfunction

    function automatic int base_lane(input logic [1:0] sz, input logic [31:0] a);
        int off = int'(a % 4);
        return off - (off % nbytes(sz));
    endfunction

    function automatic bit mis(input logic [1:0] sz, input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
        return (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'd0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic void apply(input st_t s);
        int n = nbytes(s.sz);
        int b = base_lane(s.sz, s.a);
        for (int k = 0; k < n; k++) ref_bytes[widx(s.a)*4 + b + k] = s.d[8*k +: 8];
    endfunction

    function automatic logic [31:0] load_val(input logic [1:0] sz, input logic [31:0] a, input bit sx);
        int n = nbytes(sz);
        int b = base_lane(sz, a);
        logic [31:0] v = 32'h0;
        for (int k = 0; k < n; k++) v = v | (32'(ref_bytes[widx(a)*4 + b + k]) << (8*k));
        if (sx && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    function automatic bit qhit(input logic [31:0] a);
        foreach (q[i]) if (widx(q[i].a) == widx(a)) return 1'b1;
        return 1'b0;
    endfunction

    // One request cycle: inputs applied just after a rising edge, ready checked
    // mid-cycle, outputs checked just after the following edge.
    task automatic step(input bit v, input bit we, input bit [1:0] sz, input bit sx,
                        input logic [31:0] a, input logic [31:0] wd);
        bit exp_ready, acc, rd_now;
        m_valid = v; m_we = we; m_size = sz; m_sext = sx; m_addr = a; m_wdata = wd;
        #3;
        exp_ready  = we ? (q.size() < DEP) : !qhit(a);
        last_ready = m_ready;
        chk("m_ready", {31'b0, m_ready}, {31'b0, exp_ready});
        @(posedge clk); #1;
        acc    = v && exp_ready;
        rd_now = acc && !we && !mis(sz, a);
        exp_rdv = rd_now;
        if (rd_now) exp_rd = load_val(sz, a, sx);
        if (!rd_now && q.size() > 0) apply(q.pop_front());
        if (acc && we && !mis(sz, a)) q.push_back('{a: a, sz: sz, d: wd});
        exp_al = acc && mis(sz, a);
        chk("rd_valid", {31'b0, rd_valid}, {31'b0, exp_rdv});
        chk("rd_data", rd_data, exp_rd);
        chk("wbuf_empty", {31'b0, wbuf_empty}, {31'b0, (q.size() == 0)});
`ifdef MEM_ALIGN_CHECK_EN
        chk("align_err", {31'b0, align_err}, {31'b0, exp_al});
`endif
    endtask

    task automatic reset_dut();
        m_valid = 1'b0; m_we = 1'b0; m_size = 2'd0; m_sext = 1'b0; m_addr = 32'h0; m_wdata = 32'h0;
        rst_n = 1'b0;
        #2;
        q.delete();
        exp_rdv = 1'b0; exp_rd = 32'h0; exp_al = 1'b0;
        chk("rst_rd_valid", {31'b0, rd_valid}, 32'h0);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_wbuf_empty", {31'b0, wbuf_empty}, 32'h1);
`ifdef MEM_ALIGN_CHECK_EN
        chk("rst_align_err", {31'b0, align_err}, 32'h0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit          v;
        bit          we;
        bit [1:0]    sz;
        bit          sx;
        logic [31:0] a;
        logic [31:0] wd;
        bit          e_rdy;
        bit          e_rdv;
        logic [31:0] e_rd;
    } vec_t;

    function automatic vec_t mk(input bit v, input bit we, input bit [1:0] sz, input bit sx,
                                input logic [31:0] a, input logic [31:0] wd,
                                input bit e_rdy, input bit e_rdv, input logic [31:0] e_rd);
        vec_t r;
        r.v = v; r.we = we; r.sz = sz; r.sx = sx; r.a = a; r.wd = wd;
        r.e_rdy = e_rdy; r.e_rdv = e_rdv; r.e_rd = e_rd;
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[$];
        logic [31:0] r16;
        bit          v16;

        rst_n = 1'b0;
        m_valid = 1'b0; m_we = 1'b0; m_size = 2'd0; m_sext = 1'b0; m_addr = 32'h0; m_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        reset_dut();
        chk("rst_m_ready", {31'b0, m_ready}, 32'h1);

        // Give the exercised words a known value
        for (int i = 0; i < 32; i++) step(1'b1, 1'b1, 2'd2, 1'b0, 32'(i*4), 32'h0);
        step(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);

`ifdef MEM_ALIGN_CHECK_EN
        r16 = 32'hBEEF_0000; v16 = 1'b0;
`else
        r16 = 32'hCAFE_F00D; v16 = 1'b1;
`endif
        tbl.push_back(mk(1, 1, 2'd2, 0, 32'h10, 32'h1122_3344, 1, 0, 32'h0));
        tbl.push_back(mk(0, 0, 2'd0, 0, 32'h00, 32'h0,         1, 0, 32'h0));
        tbl.push_back(mk(1, 0, 2'd2, 0, 32'h10, 32'h0,         1, 1, 32'h1122_3344));
        tbl.push_back(mk(1, 1, 2'd0, 0, 32'h21, 32'h80,        1, 0, 32'h1122_3344));
        tbl.push_back(mk(0, 0, 2'd0, 0, 32'h00, 32'h0,         1, 0, 32'h1122_3344));
        tbl.push_back(mk(1, 0, 2'd0, 1, 32'h21, 32'h0,         1, 1, 32'hFFFF_FF80));
        tbl.push_back(mk(1, 0, 2'd0, 0, 32'h21, 32'h0,         1, 1, 32'h0000_0080));
        tbl.push_back(mk(1, 0, 2'd2, 0, 32'h20, 32'h0,         1, 1, 32'h0000_8000));
        tbl.push_back(mk(1, 1, 2'd1, 0, 32'h32, 32'hBEEF,      1, 0, 32'h0000_8000));
        tbl.push_back(mk(1, 0, 2'd1, 1, 32'h32, 32'h0,         0, 0, 32'h0000_8000));
        tbl.push_back(mk(1, 0, 2'd1, 1, 32'h32, 32'h0,         1, 1, 32'hFFFF_BEEF));
        tbl.push_back(mk(1, 0, 2'd1, 0, 32'h32, 32'h0,         1, 1, 32'h0000_BEEF));
        tbl.push_back(mk(1, 0, 2'd2, 0, 32'h30, 32'h0,         1, 1, 32'hBEEF_0000));
        tbl.push_back(mk(1, 1, 2'd2, 0, 32'h40, 32'hCAFE_F00D, 1, 0, 32'hBEEF_0000));
        tbl.push_back(mk(0, 0, 2'd0, 0, 32'h00, 32'h0,         1, 0, 32'hBEEF_0000));
        tbl.push_back(mk(1, 0, 2'd2, 0, 32'h41, 32'h0,         1, v16, r16));
        tbl.push_back(mk(1, 1, 2'd0, 0, 32'h13, 32'h5A,        1, 0, r16));
        tbl.push_back(mk(0, 0, 2'd0, 0, 32'h00, 32'h0,         1, 0, r16));
        tbl.push_back(mk(1, 0, 2'd2, 0, 32'h2000_0010, 32'h0,  1, 1, 32'h5A22_3344));

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].we, tbl[i].sz, tbl[i].sx, tbl[i].a, tbl[i].wd);
            chk($sformatf("tbl%0d_ready", i), {31'b0, last_ready}, {31'b0, tbl[i].e_rdy});
            chk($sformatf("tbl%0d_rd_valid", i), {31'b0, rd_valid}, {31'b0, tbl[i].e_rdv});
            chk($sformatf("tbl%0d_rd_data", i), rd_data, tbl[i].e_rd);
        end

        // Loads back to back keep the pending store parked; an idle cycle drains it
        step(1, 1, 2'd2, 0, 32'h60, 32'hAAAA_0001);
        step(1, 1, 2'd2, 0, 32'h64, 32'hBBBB_0002);
        step(1, 0, 2'd2, 0, 32'h00, 32'h0);
        step(1, 0, 2'd2, 0, 32'h04, 32'h0);
        step(1, 0, 2'd2, 0, 32'h08, 32'h0);
        chk("b2b_pending", {31'b0, wbuf_empty}, 32'h0);
        step(0, 0, 2'd0, 0, 32'h00, 32'h0);
        chk("b2b_drained", {31'b0, wbuf_empty}, 32'h1);
        step(1, 0, 2'd2, 0, 32'h64, 32'h0);
        chk("b2b_data", rd_data, 32'hBBBB_0002);

        // Reset with a store still buffered discards it
        step(1, 1, 2'd2, 0, 32'h50, 32'hDEAD_BEEF);
        chk("pre_rst_pending", {31'b0, wbuf_empty}, 32'h0);
        reset_dut();
        step(1, 0, 2'd2, 0, 32'h50, 32'h0);
        chk("rst_discard", rd_data, 32'h0);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] ra;
            ra = (32'($urandom_range(0, 3)) << (AW + 2)) | (32'($urandom_range(0, 31)) << 2)
               | 32'($urandom_range(0, 3));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 1) == 1, ra, $urandom);
        end
        m_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
